stream_reorder_sched: RTL and testbench
=======================================

Name: stream_reorder_sched

Overview:
- Round-robin scheduler that shares one registered streaming-reorder unit between NREQ requesters.
- The unit computes the left-stream slice reversal {<< s {data}} of each request word.
- Sits between multiple producers of packed words and a single downstream consumer.
- Uses a valid/ready handshake on every side, with one output pipeline register.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 8, data width in bits; must be a multiple of 4.
- CNTW, 16, width of the transfer counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*W  packed request words; requester i occupies bits [i*W +: W].
- req_slice  in  NREQ*2  packed slice codes; requester i occupies bits [i*2 +: 2]. Codes: 0=1-bit, 1=2-bit, 2=4-bit, 3=reserved.
- req_ready  out  NREQ  per-requester accept.
- out_valid  out  1  output word valid.
- out_data  out  W  reordered word.
- out_id  out  clog2(NREQ) (min 1)  index of the source requester.
- out_err  out  1  reserved slice code was used.
- out_ready  in  1  downstream accept.
- xfer_cnt  out  CNTW  count of accepted requests.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, out_err=0, xfer_cnt=0. Round-robin pointer is set so requester 0 has top priority.
- Datapath:
  - Slice reorder is combinational: the W-bit word is split into chunks of s bits, chunk 0 taken from the LSB end. Chunk order is reversed; bit order within each chunk is kept.
  - Code 3: data passes through unchanged and out_err=1 for that word.
- Output stage:
  - can_load = !out_valid || out_ready.
  - grant = first requester with req_valid=1, searching from (last_granted+1) mod NREQ upward with wrap.
  - req_ready[grant] = can_load. All other req_ready bits = 0. req_ready is combinational and may not depend on out_ready through any other path.
- Acceptance when req_valid[g] && req_ready[g]:
  - On the next edge: out_valid=1, out_data=reorder(g), out_id=g, out_err per code, last_granted=g, xfer_cnt+1.
  - xfer_cnt wraps modulo 2^CNTW with no flag.
- Latency: 1 cycle from acceptance to out_valid. Throughput is 1 word/cycle while out_ready=1.
- No acceptance and out_ready=1: out_valid clears; out_data, out_id and out_err hold their last values.
- Backpressure: while out_valid && !out_ready, all output fields hold stable and every req_ready=0. The pointer does not move.
- Requester rules: once req_valid is raised it stays high, with data and slice stable, until accepted. The scheduler does not check this. A request withdrawn early is never granted that cycle and is not counted.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,..,NREQ-1,0.
  - A requester waits at most NREQ-1 accepted transfers.
  - A lone requester is granted every cycle.
- Same-edge events: if out_ready=1 and a request is accepted on the same edge, the new word replaces the old one with no bubble.
- Reset mid-transfer: the pending output word is discarded, with no out_valid afterwards. In-flight requests stay pending at their source.

Test Plan:
1. W=8. Requester 0 sends 0xA4 with slice codes 0, 1, 2 in turn, out_ready=1 -> out_data = 0x25, 0x1A, 0x4A, each 1 cycle after acceptance. out_id=0, out_err=0, xfer_cnt=3.
2. Requester 1 sends 0x3C with code 3 -> out_data=0x3C, out_err=1, out_id=1.
3. Both requesters held valid, out_ready=1, 6 cycles -> out_id sequence 0,1,0,1,0,1 with no idle cycle; xfer_cnt=6.
4. Output holds 0x1A, out_ready=0 for 4 cycles with both requesters valid -> out_data stays 0x1A, req_ready=00 throughout. When out_ready returns to 1, the next grant goes to the requester after the last granted one.
5. xfer_cnt preset near wrap (CNTW=4, 17 transfers) -> xfer_cnt reads 1.
6. rst_n pulsed low while out_valid=1 and out_ready=0 -> all outputs 0 immediately. After release, requester 0 has priority.

Source files
------------

// File: rtl/stream_reorder_sched.sv
// stream_reorder_sched: round-robin arbiter feeding one registered slice-reversal stage.
// Each granted word has its s-bit chunks reversed (s = 1, 2 or 4); code 3 passes through flagged.
module stream_reorder_sched #(
    parameter int NREQ = 2,
    parameter int W    = 8,
    parameter int CNTW = 16,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ*2-1:0] req_slice,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_err,
    input  logic              out_ready,
    output logic [CNTW-1:0]   xfer_cnt
);
    logic [IDW-1:0]  r_last, r_id, w_grant;
    logic            r_valid, r_err, w_found, w_can_load;
    logic [W-1:0]    r_data, w_word;
    logic [1:0]      w_code;
    logic [CNTW-1:0] r_cnt;

    function automatic logic [W-1:0] f_reorder(input logic [W-1:0] d, input logic [1:0] c);
        logic [W-1:0] r;
        int s;
        s = 1 << c;
        r = d;
        if (c != 2'd3)
            for (int k = 0; k < W; k++)
                r[k] = d[(W / s - 1 - k / s) * s + k % s];
        return r;
    endfunction

    // Scan downward so the nearest requester after r_last is the one left standing.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = NREQ; k >= 1; k--)
            if (req_valid[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_grant = IDW'((int'(r_last) + k) % NREQ);
            end
    end

    assign w_can_load = !r_valid || out_ready;
    assign req_ready  = (w_found && w_can_load) ? (NREQ'(1) << w_grant) : '0;
    assign w_word     = req_data[int'(w_grant) * W +: W];
    assign w_code     = req_slice[int'(w_grant) * 2 +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_last  <= IDW'(NREQ - 1);
        end else if (w_can_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_data <= f_reorder(w_word, w_code);
                r_id   <= w_grant;
                r_err  <= (w_code == 2'd3);
                r_last <= w_grant;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign out_err   = r_err;
    assign xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_stream_reorder_sched.sv
// tb_stream_reorder_sched: directed and random checks of the scheduler against a
// chunk-arithmetic reference model; CNTW is shrunk to 4 so counter wrap is reachable.
module tb_stream_reorder_sched;
    localparam int NREQ = 2, W = 8, CNTW = 4;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ*2-1:0] req_slice = '0;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid, out_err, out_ready = 1'b0;
    logic [W-1:0]      out_data;
    logic [0:0]        out_id;
    logic [CNTW-1:0]   xfer_cnt;

    int n_tests = 0, n_fail = 0;
    int m_last, m_id, m_cnt, m_g;
    bit m_valid, m_err;
    logic [W-1:0] m_data;

    stream_reorder_sched #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_slice(req_slice), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_id(out_id), .out_err(out_err),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_rev(input logic [W-1:0] d, input logic [1:0] c);
        int s, n;
        logic [W-1:0] r;
        if (c == 2'd3) return d;
        s = 1 << c;
        n = W / s;
        r = '0;
        for (int j = 0; j < n; j++)
            r |= ((d >> (j * s)) & W'((1 << s) - 1)) << ((n - 1 - j) * s);
        return r;
    endfunction

    function automatic int ref_grant();
        for (int k = 1; k <= NREQ; k++)
            if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".data"},  32'(out_data),  32'(m_data));
        chk({tag, ".id"},    32'(out_id),    m_id);
        chk({tag, ".err"},   32'(out_err),   32'(m_err));
        chk({tag, ".cnt"},   32'(xfer_cnt),  m_cnt);
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_cnt = 0; m_last = NREQ - 1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_out(tag);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // One clock: check req_ready before the edge, advance the model, check outputs after.
    task automatic tick(input string tag);
        bit cl;
        #1;
        m_g = ref_grant();
        cl = !m_valid || out_ready;
        chk({tag, ".rdy"}, 32'(req_ready), (m_g >= 0 && cl) ? (32'd1 << m_g) : 32'd0);
        @(posedge clk);
        if (cl && m_g >= 0) begin
            m_valid = 1;
            m_data  = ref_rev(req_data[m_g * W +: W], req_slice[m_g * 2 +: 2]);
            m_id    = m_g;
            m_err   = (req_slice[m_g * 2 +: 2] == 2'd3);
            m_last  = m_g;
            m_cnt   = (m_cnt + 1) % (1 << CNTW);
        end else begin
            if (cl) m_valid = 0;
            m_g = -1;
        end
        #1;
        check_out(tag);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d, input logic [1:0] c, input bit v);
        req_valid[i] = v;
        req_data[i * W +: W] = d;
        req_slice[i * 2 +: 2] = c;
    endtask

    initial begin
        do_reset("reset");
        out_ready = 1'b1;
        set_req(0, 8'hA4, 2'd0, 1); tick("t1_s1"); chk("t1_s1.const", 32'(out_data), 32'h25);
        set_req(0, 8'hA4, 2'd1, 1); tick("t1_s2"); chk("t1_s2.const", 32'(out_data), 32'h1A);
        set_req(0, 8'hA4, 2'd2, 1); tick("t1_s4"); chk("t1_s4.const", 32'(out_data), 32'h4A);
        chk("t1.id", 32'(out_id), 0);
        chk("t1.cnt", 32'(xfer_cnt), 3);
        set_req(0, 8'h00, 2'd0, 0); tick("t1_idle");
        chk("t1_idle.valid", 32'(out_valid), 0);
        chk("t1_idle.hold", 32'(out_data), 32'h4A);
        set_req(1, 8'h3C, 2'd3, 1); tick("t2");
        chk("t2.const", {out_err, out_id, out_data}, {1'b1, 1'b1, 8'h3C});
        set_req(1, 8'h00, 2'd0, 0);
        do_reset("t3_rst");
        set_req(0, 8'h11, 2'd0, 1); set_req(1, 8'h22, 2'd1, 1);
        for (int i = 0; i < 6; i++) begin
            tick("t3");
            chk("t3.rot", 32'(out_id), i % 2);
            chk("t3.valid", 32'(out_valid), 1);
            set_req(i % 2, W'($urandom), 2'($urandom_range(0, 2)), 1);
        end
        chk("t3.cnt", 32'(xfer_cnt), 6);
        set_req(0, 8'hA4, 2'd1, 1); tick("t4_load");
        chk("t4_load.const", 32'(out_data), 32'h1A);
        out_ready = 1'b0;
        set_req(0, 8'h55, 2'd0, 1);
        for (int i = 0; i < 4; i++) begin
            tick("t4_stall");
            chk("t4_stall.hold", 32'(out_data), 32'h1A);
        end
        out_ready = 1'b1; tick("t4_resume");
        chk("t4_resume.id", 32'(out_id), 1);
        set_req(0, 8'h00, 2'd0, 0); set_req(1, 8'h00, 2'd0, 0);
        do_reset("t5_rst");
        set_req(0, 8'h81, 2'd2, 1);
        for (int i = 0; i < 17; i++) tick("t5");
        chk("t5.wrap", 32'(xfer_cnt), 1);
        out_ready = 1'b0;
        set_req(1, 8'h96, 2'd1, 1);
        tick("t6_stall");
        chk("t6_stall.valid", 32'(out_valid), 1);
        do_reset("t6_rst");
        chk("t6_rst.valid", 32'(out_valid), 0);
        out_ready = 1'b1; tick("t6_after");
        chk("t6_after.id", 32'(out_id), 0);
        set_req(0, 8'h00, 2'd0, 0); set_req(1, 8'h00, 2'd0, 0);
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NREQ; r++)
                if (!req_valid[r] && $urandom_range(0, 1) == 1)
                    set_req(r, W'($urandom), 2'($urandom), 1);
            tick("rnd");
            if (m_g >= 0) req_valid[m_g] = 1'b0;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
